seq_divider: RTL

//  Iterative restoring divider; the inverse of the ALU multiplier path. Computes

---
 rtl/seq_divider.sv | 132 +++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock behind a start/done handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module seq_divider #(
    parameter int INPUTSIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [INPUTSIZE-1:0] a,
    input  logic [INPUTSIZE-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [INPUTSIZE-1:0] q,
    output logic [INPUTSIZE-1:0] rem,
    output logic                 dz,
    output logic                 zf
);
    localparam int N  = INPUTSIZE;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [N-1:0]  prem, dvd, div;
    logic [CW-1:0] cnt;

    logic [N-1:0]  a_mag, b_mag;
    logic [N-1:0]  src_prem, src_dvd, src_div;
    logic [N:0]    trial;
    logic          ge;
    logic [N-1:0]  nxt_prem, nxt_dvd;
    logic [N-1:0]  fin_q, fin_r;

`ifdef DIVIDER_SIGNED_EN
    logic neg_q, neg_r;
`endif

    // The first iteration runs on the accepting edge straight from the operand
    // inputs, so the N-th iteration lands in time for done in the N-th cycle.
    always_comb begin
`ifdef DIVIDER_SIGNED_EN
        a_mag = a[N-1] ? -a : a;
        b_mag = b[N-1] ? -b : b;
`else
        a_mag = a;
        b_mag = b;
`endif
        if (state == RUN) begin
            src_prem = prem;
            src_dvd  = dvd;
            src_div  = div;
        end else begin
            src_prem = '0;
            src_dvd  = a_mag;
            src_div  = b_mag;
        end
        trial    = {src_prem, src_dvd[N-1]};
        ge       = (trial >= {1'b0, src_div});
        nxt_prem = ge ? (trial[N-1:0] - src_div) : trial[N-1:0];
        nxt_dvd  = {src_dvd[N-2:0], ge};
`ifdef DIVIDER_SIGNED_EN
        fin_q = neg_q ? -nxt_dvd : nxt_dvd;
        fin_r = neg_r ? -nxt_prem : nxt_prem;
`else
        fin_q = nxt_dvd;
        fin_r = nxt_prem;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            dz    <= 1'b0;
            zf    <= 1'b1;
            q     <= '0;
            rem   <= '0;
            prem  <= '0;
            dvd   <= '0;
            div   <= '0;
            cnt   <= '0;
`ifdef DIVIDER_SIGNED_EN
            neg_q <= 1'b0;
            neg_r <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    prem <= nxt_prem;
                    dvd  <= nxt_dvd;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        q     <= fin_q;
                        rem   <= fin_r;
                        dz    <= 1'b0;
                        zf    <= (fin_q == '0);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        div <= b_mag;
`ifdef DIVIDER_SIGNED_EN
                        neg_q <= a[N-1] ^ b[N-1];
                        neg_r <= a[N-1];
`endif
                        if (b == '0) begin
                            q     <= '1;
                            rem   <= a;
                            dz    <= 1'b1;
                            zf    <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            prem  <= nxt_prem;
                            dvd   <= nxt_dvd;
                            cnt   <= CW'(N - 1);
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
